// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   F3_*          RISC-V load/store width codes seen on the func3 field
//   prio_e        arbitration priority state (core or DMA master favoured)
//   access_legal  alignment/encoding check for one request
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    PRI_CORE = 1'b0,
    PRI_DMA  = 1'b1
  } prio_e;

  // Unsigned widths only exist for loads; stores accept B/H/W only.
  function automatic logic access_legal(input logic [1:0] addr_lo,
                                        input logic [2:0] func3,
                                        input logic       we);
    logic legal;
    case (func3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      F3_BU:   legal = ~we;
      F3_HU:   legal = ~we & ~addr_lo[0];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality check for the granted request.
//   addr_lo  low two bits of the byte address
//   func3    RISC-V width code
//   we       1 = store, 0 = load
//   legal    1 when the access may proceed to memory
module dmem_access_check
  import dmem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] func3,
  input  logic       we,
  output logic       legal
);

  assign legal = access_legal(addr_lo, func3, we);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single datamem port between the core LSU (port 0)
// and a DMA/debug master (port 1).
//   clk, rst_n        clock and asynchronous active-low reset
//   rN_req_*          valid/ready request channel (addr, we, func3, wdata)
//   rN_rsp_*          registered one-cycle response (valid, rdata, err)
//   mem_*             drive/receive the datamem ports (async read data)
// STARVE_LIMIT bounds how many consecutive cycles port 1 can lose while valid.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [31:0] r0_addr,
  input  logic        r0_we,
  input  logic [2:0]  r0_func3,
  input  logic [31:0] r0_wdata,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_rdata,
  output logic        r0_rsp_err,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [31:0] r1_addr,
  input  logic        r1_we,
  input  logic [2:0]  r1_func3,
  input  logic [31:0] r1_wdata,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_rdata,
  output logic        r1_rsp_err,

  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

  prio_e       prio_q, prio_d;
  logic [3:0]  starve_q, starve_d;
  logic        r0_rsp_valid_q, r0_rsp_valid_d;
  logic [31:0] r0_rsp_rdata_q, r0_rsp_rdata_d;
  logic        r0_rsp_err_q, r0_rsp_err_d;
  logic        r1_rsp_valid_q, r1_rsp_valid_d;
  logic [31:0] r1_rsp_rdata_q, r1_rsp_rdata_d;
  logic        r1_rsp_err_q, r1_rsp_err_d;

  logic        dma_first;
  logic        gnt0, gnt1;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_func3;
  logic        sel_we;
  logic        legal;
  logic        load_ok;

  // Grants are masked by rst_n so memory sees nothing while in reset.
  assign dma_first    = (prio_q == PRI_DMA) & r1_req_valid;
  assign gnt0         = rst_n & r0_req_valid & ~dma_first;
  assign gnt1         = rst_n & r1_req_valid & ~gnt0;
  assign r0_req_ready = rst_n & ~dma_first;
  assign r1_req_ready = rst_n & (~r0_req_valid | (prio_q == PRI_DMA));

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_func3 = '0;
    sel_we    = 1'b0;
    if (gnt0) begin
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      sel_func3 = r0_func3;
      sel_we    = r0_we;
    end else if (gnt1) begin
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
      sel_func3 = r1_func3;
      sel_we    = r1_we;
    end
  end

  dmem_access_check u_check (
    .addr_lo (sel_addr[1:0]),
    .func3   (sel_func3),
    .we      (sel_we),
    .legal   (legal)
  );

  assign mem_address  = sel_addr;
  assign mem_func3    = sel_func3;
  assign mem_data_in  = sel_wdata;
  assign mem_write_en = (gnt0 | gnt1) & sel_we & legal;
  assign load_ok      = ~sel_we & legal;

  // Starvation counter: once port 1 has lost STARVE_LIMIT times in a row,
  // it is favoured for exactly one grant.
  always_comb begin
    prio_d   = prio_q;
    starve_d = starve_q;
    if (gnt1 | ~r1_req_valid) begin
      starve_d = '0;
    end else if (gnt0) begin
      if (starve_q == STARVE_MAX) begin
        starve_d = '0;
        prio_d   = PRI_DMA;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
    if (gnt1) begin
      prio_d = PRI_CORE;
    end
  end

  // A response register holds only for the cycle after its grant.
  always_comb begin
    r0_rsp_valid_d = gnt0;
    r0_rsp_rdata_d = (gnt0 & load_ok) ? mem_data_out : '0;
    r0_rsp_err_d   = gnt0 & ~legal;
    r1_rsp_valid_d = gnt1;
    r1_rsp_rdata_d = (gnt1 & load_ok) ? mem_data_out : '0;
    r1_rsp_err_d   = gnt1 & ~legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q         <= PRI_CORE;
      starve_q       <= '0;
      r0_rsp_valid_q <= 1'b0;
      r0_rsp_rdata_q <= '0;
      r0_rsp_err_q   <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r1_rsp_rdata_q <= '0;
      r1_rsp_err_q   <= 1'b0;
    end else begin
      prio_q         <= prio_d;
      starve_q       <= starve_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r0_rsp_rdata_q <= r0_rsp_rdata_d;
      r0_rsp_err_q   <= r0_rsp_err_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r1_rsp_rdata_q <= r1_rsp_rdata_d;
      r1_rsp_err_q   <= r1_rsp_err_d;
    end
  end

  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r0_rsp_rdata = r0_rsp_rdata_q;
  assign r0_rsp_err   = r0_rsp_err_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r1_rsp_rdata = r1_rsp_rdata_q;
  assign r1_rsp_err   = r1_rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-addressed
// behavioural datamem (async read, write on the rising edge).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_we;
  logic [31:0] r0_addr, r0_wdata;
  logic [2:0]  r0_func3;
  logic        r0_rsp_valid, r0_rsp_err;
  logic [31:0] r0_rsp_rdata;
  logic        r1_req_valid, r1_req_ready, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic [2:0]  r1_func3;
  logic        r1_rsp_valid, r1_rsp_err;
  logic [31:0] r1_rsp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_en;
  logic [2:0]  mem_func3;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  logic [7:0] mem [0:255];

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_addr      (r0_addr),
    .r0_we        (r0_we),
    .r0_func3     (r0_func3),
    .r0_wdata     (r0_wdata),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_rdata (r0_rsp_rdata),
    .r0_rsp_err   (r0_rsp_err),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_addr      (r1_addr),
    .r1_we        (r1_we),
    .r1_func3     (r1_func3),
    .r1_wdata     (r1_wdata),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_rdata (r1_rsp_rdata),
    .r1_rsp_err   (r1_rsp_err),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_func3    (mem_func3),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datamem: extends loads according to func3.
  function automatic logic [31:0] read_mem(input logic [7:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a];
    b1 = mem[8'(a + 8'd1)];
    b2 = mem[8'(a + 8'd2)];
    b3 = mem[8'(a + 8'd3)];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  assign mem_data_out = read_mem(mem_address[7:0], mem_func3);

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_func3 == 3'b001 || mem_func3 == 3'b010)
        mem[8'(mem_address[7:0] + 8'd1)] <= mem_data_in[15:8];
      if (mem_func3 == 3'b010) begin
        mem[8'(mem_address[7:0] + 8'd2)] <= mem_data_in[23:16];
        mem[8'(mem_address[7:0] + 8'd3)] <= mem_data_in[31:24];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a port presents a response.
  always @(negedge clk) begin
    if (r0_rsp_valid) begin
      if (exp_q0.size() == 0) begin
        checkOutput("r0_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q0.pop_front();
        checkOutput("r0_rdata", r0_rsp_rdata, e.rdata);
        checkOutput("r0_err", {31'd0, r0_rsp_err}, {31'd0, e.err});
      end
    end
    if (r1_rsp_valid) begin
      if (exp_q1.size() == 0) begin
        checkOutput("r1_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q1.pop_front();
        checkOutput("r1_rdata", r1_rsp_rdata, e.rdata);
        checkOutput("r1_err", {31'd0, r1_rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Issue one request on a port; entered and left at a falling edge.
  task automatic applyStimulus(input int port, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic exp_mem_we);
    exp_t e;
    bit   done;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (port == 0) begin
      r0_req_valid = 1'b1; r0_we = we; r0_func3 = f3; r0_addr = addr; r0_wdata = wdata;
      exp_q0.push_back(e);
    end else begin
      r1_req_valid = 1'b1; r1_we = we; r1_func3 = f3; r1_addr = addr; r1_wdata = wdata;
      exp_q1.push_back(e);
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((port == 0) ? r0_req_ready : r1_req_ready) begin
        checkOutput("mem_write_en", {31'd0, mem_write_en}, {31'd0, exp_mem_we});
        checkOutput("mem_address", mem_address, addr);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    if (port == 0) r0_req_valid = 1'b0;
    else r1_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_r0_ready [1:6];
    bit exp_r1_ready [1:6];
    exp_t e;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    r0_req_valid = 1'b1; r0_we = 1'b0; r0_func3 = F3_W; r0_addr = 32'h4; r0_wdata = '0;
    r1_req_valid = 1'b1; r1_we = 1'b1; r1_func3 = F3_W; r1_addr = 32'h8; r1_wdata = 32'h1;

    // Reset state, with requests pending so masking is visible
    #3;
    checkOutput("rst_r0_ready", {31'd0, r0_req_ready}, 32'd0);
    checkOutput("rst_r1_ready", {31'd0, r1_req_ready}, 32'd0);
    checkOutput("rst_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
    checkOutput("rst_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    checkOutput("rst_mem_address", mem_address, 32'd0);
    checkOutput("rst_mem_write_en", {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load via port 0
    applyStimulus(0, 1'b1, F3_W, 32'h4, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, F3_W, 32'h4, 32'h0, 32'hAABBCCDD, 1'b0, 1'b0);

    // Byte path via port 1
    applyStimulus(1, 1'b1, F3_B, 32'h5, 32'h000000EE, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, F3_B, 32'h5, 32'h0, 32'hFFFFFFEE, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, F3_BU, 32'h5, 32'h0, 32'h000000EE, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, F3_W, 32'h4, 32'h0, 32'hAABBEEDD, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, F3_W, 32'h8, 32'h11223344, 32'h0, 1'b0, 1'b1);

    // Contention: both ports valid for six cycles
    exp_r0_ready = '{1, 1, 1, 1, 0, 1};
    exp_r1_ready = '{0, 0, 0, 0, 1, 0};
    e.rdata = 32'hAABBEEDD; e.err = 1'b0;
    for (int i = 0; i < 5; i++) exp_q0.push_back(e);
    e.rdata = 32'h11223344;
    exp_q1.push_back(e);
    r0_req_valid = 1'b1; r0_we = 1'b0; r0_func3 = F3_W; r0_addr = 32'h4;
    r1_req_valid = 1'b1; r1_we = 1'b0; r1_func3 = F3_W; r1_addr = 32'h8;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      #1;
      checkOutput($sformatf("cont_r0_ready_c%0d", cyc), {31'd0, r0_req_ready}, {31'd0, exp_r0_ready[cyc]});
      checkOutput($sformatf("cont_r1_ready_c%0d", cyc), {31'd0, r1_req_ready}, {31'd0, exp_r1_ready[cyc]});
      @(posedge clk);
      #1;
      if (cyc == 4) checkOutput("cont_prio_dma", {31'd0, dut.prio_q}, {31'd0, PRI_DMA});
      if (cyc == 5) checkOutput("cont_starve_after_gnt1", {28'd0, dut.starve_q}, 32'd0);
      @(negedge clk);
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    @(negedge clk);

    // Misalignment
    applyStimulus(1, 1'b0, F3_W, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, F3_H, 32'h5, 32'h00001234, 32'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, F3_W, 32'h4, 32'h0, 32'hAABBEEDD, 1'b0, 1'b0);

    // Illegal func3 encodings
    applyStimulus(0, 1'b1, 3'b100, 32'h8, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, F3_W, 32'h8, 32'h0, 32'h11223344, 1'b0, 1'b0);

    // Reset in the cycle after an accepted load (port 1 loses, so starve is 1)
    r0_req_valid = 1'b1; r0_we = 1'b0; r0_func3 = F3_W; r0_addr = 32'h4;
    r1_req_valid = 1'b1; r1_we = 1'b0; r1_func3 = F3_W; r1_addr = 32'h8;
    @(posedge clk);
    #1;
    checkOutput("pre_rst_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
    checkOutput("pre_rst_starve", {28'd0, dut.starve_q}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
    checkOutput("mid_rst_rsp_rdata", r0_rsp_rdata, 32'd0);
    checkOutput("mid_rst_r0_ready", {31'd0, r0_req_ready}, 32'd0);
    checkOutput("mid_rst_r1_ready", {31'd0, r1_req_ready}, 32'd0);
    checkOutput("mid_rst_mem_address", mem_address, 32'd0);
    checkOutput("mid_rst_starve", {28'd0, dut.starve_q}, 32'd0);
    checkOutput("mid_rst_prio", {31'd0, dut.prio_q}, {31'd0, PRI_CORE});
    @(negedge clk);
    @(negedge clk);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, F3_W, 32'h4, 32'h0, 32'hAABBEEDD, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("r0_queue_empty", exp_q0.size(), 32'd0);
    checkOutput("r1_queue_empty", exp_q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the RISC-V data memory (`datamem`). It shares the single memory port between the core load/store unit (port 0) and a DMA/debug master (port 1). Each port uses a valid/ready request handshake and gets a registered one-cycle response. The block also rejects misaligned or illegal `func3` accesses before they reach memory, and bounds DMA starvation with a counter.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles port 1 may lose arbitration while valid before it gets priority; legal range 1..15.
- `clk` in 1: single clock; memory writes and all state update on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rN_req_valid` in 1: request valid, for N = 0, 1.
- `rN_req_ready` out 1: request accepted this cycle when valid and ready are both high.
- `rN_addr` in 32: byte address.
- `rN_we` in 1: 1 = store, 0 = load.
- `rN_func3` in 3: RISC-V width code (B=000, H=001, W=010, BU=100, HU=101).
- `rN_wdata` in 32: store data, right-aligned.
- `rN_rsp_valid` out 1: one-cycle response pulse. No response back-pressure.
- `rN_rsp_rdata` out 32: load result, already extended by memory; 0 for stores and errors.
- `rN_rsp_err` out 1: access rejected, valid with `rN_rsp_valid`.
- `mem_address` out 32, `mem_write_en` out 1, `mem_func3` out 3, `mem_data_in` out 32: drive the `datamem` ports.
- `mem_data_out` in 32: asynchronous read data from `datamem`.

## Operation
- Priority state register `prio`, values PRI_CORE and PRI_DMA; resets to PRI_CORE.
- Grant rules:
  - `gnt0 = r0_req_valid & !(prio==PRI_DMA & r1_req_valid)`.
  - `gnt1 = r1_req_valid & !gnt0`.
- Ready rules:
  - `r0_req_ready = rst_n & !(prio==PRI_DMA & r1_req_valid)`.
  - `r1_req_ready = rst_n & (!r0_req_valid | prio==PRI_DMA)`.
- Starvation counter `starve` (4 bits):
  - Increments when `r1_req_valid & gnt0`.
  - Clears when `gnt1` or `!r1_req_valid`.
  - When `starve == STARVE_LIMIT-1` and it would increment, `prio` becomes PRI_DMA and the counter clears.
  - `prio` returns to PRI_CORE on the cycle after `gnt1`.
- Memory drive:
  - The granted port's addr, func3 and wdata pass combinationally to the `mem_*` outputs.
  - `mem_write_en = granted & we & legal`.
  - With no grant, all `mem_*` outputs are 0.
- Legality, checked combinationally on the granted request:
  - H/HU require `addr[0]==0`; W requires `addr[1:0]==0`.
  - Loads accept func3 in {000, 001, 010, 100, 101}; stores accept func3 in {000, 001, 010}.
  - Anything else is illegal.
- An illegal request is still accepted (ready high). Memory is not written, and the response returns `err=1`, `rdata=0`.
- Response register per port, loaded on the edge that accepts the request:
  - `rsp_valid=1`.
  - `rdata = (load & legal) ? mem_data_out : 0`.
  - `err = !legal`.
  - Cleared the following edge unless a new grant to that port occurs.

## Timing
- Throughput: one access per cycle total, across both ports.
- Load latency: the response is valid in the cycle after acceptance, and `mem_data_out` is sampled at the accepting edge. A load issued in the cycle after a store to the same word returns the new data.
- Store: memory is updated at the accepting edge. The response pulse (err=0, rdata=0) follows one cycle later.
- Simultaneous valid on both ports: the port given by `prio` wins. The loser's ready stays low and it must hold its request stable.
- Reset values: all `rN_rsp_*` = 0, `starve` = 0, `prio` = PRI_CORE. Both readys are 0 while `rst_n` is low, and all `mem_*` outputs are 0.
- Reset asserted mid-operation: pending responses are dropped immediately (asynchronous). Memory contents are not reset. A write on an edge concurrent with `rst_n` falling has undefined effect.

## Structure
- Shared package `dmem_pkg` holds:
  - the func3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the `prio` state encodings;
  - the legality function.
- One combinational sub-module, `dmem_access_check` (inputs: addr[1:0], func3, we; output: legal), shared by both ports.
- The arbiter, counter and response registers stay in `dmem_arbiter`.

## Test plan
- Store then load: r0 SW addr 0x4, data 0xAABBCCDD; next cycle r0 LW 0x4. Required: r0_rsp_valid the cycle after, rdata 0xAABBCCDD, err 0.
- Byte path via r1: SB 0xEE at 0x5, then LB 0x5 → 0xFFFFFFEE, then LBU 0x5 → 0x000000EE. A following LW 0x4 returns 0xAABBEEDD.
- Contention with STARVE_LIMIT=4 and both ports continuously valid:
  - r0 is granted 4 cycles, r1 on the 5th, r0 again on the 6th.
  - `starve` reads 0 after the r1 grant.
- Misalignment: r1 LW 0x6 → accepted, mem_write_en 0, next cycle r1_rsp_err 1, rdata 0. r0 SH 0x5 value 0x1234 → err 1, and memory word 0x4 is unchanged.
- Illegal func3: store with func3 100 and load with func3 011 → both return err 1, and no memory write occurs.
- Reset: drop rst_n in the cycle after accepting an LW. Required: rsp_valid falls immediately, both readys are 0, and `prio`/`starve` return to reset values. After release, memory contents are preserved (LW 0x4 returns the prior value).
